// File: rtl/uart_loop_ctrl.sv
// uart_loop_ctrl
//   Loopback sequencer between the UART receiver and transmitter. Received bytes are
//   queued in a small circular FIFO and replayed one frame at a time through a
//   TX_En_Sig / TX_Done_Sig handshake. An idle gap follows each completed frame.
//   A frame the transmitter never finishes is aborted after TO_CYCLES clocks.
//
// Parameters
//   ADDR_W      FIFO address width, depth = 2**ADDR_W
//   GAP_CYCLES  idle clocks after each TX_Done_Sig before the next launch (0 = none)
//   TO_CYCLES   maximum clocks spent waiting for TX_Done_Sig (must be >= 1)
//
// Ports
//   CLK, RSTn      clock, asynchronous active-low reset
//   RX_Data        received byte, valid while RX_Done_Sig is high
//   RX_Done_Sig    one-cycle receive strobe
//   TX_Done_Sig    one-cycle strobe when the transmitter finishes a stop bit
//   Loop_En        1 = launch queued frames, 0 = hold them
//   Flag_Clr       clears Overflow_Sig and Timeout_Sig
//   TX_Data        byte presented to the transmitter
//   TX_En_Sig      transmit request level
//   Fifo_Count     FIFO occupancy
//   Overflow_Sig   sticky: a byte was dropped on a full FIFO
//   Timeout_Sig    sticky: a frame was aborted by the timeout
//   Busy           high while a frame or its trailing gap is in progress

module uart_loop_ctrl #(
   parameter int unsigned ADDR_W     = 2,
   parameter int unsigned GAP_CYCLES = 16,
   parameter int unsigned TO_CYCLES  = 1_000_000
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [7:0]        RX_Data,
   input  logic              RX_Done_Sig,
   input  logic              TX_Done_Sig,
   input  logic              Loop_En,
   input  logic              Flag_Clr,
   output logic [7:0]        TX_Data,
   output logic              TX_En_Sig,
   output logic [ADDR_W:0]   Fifo_Count,
   output logic              Overflow_Sig,
   output logic              Timeout_Sig,
   output logic              Busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned TO_W  = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
   localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);
   localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e             state_q;
   logic [7:0]         mem [DEPTH];
   logic [ADDR_W-1:0]  wr_ptr_q;
   logic [ADDR_W-1:0]  rd_ptr_q;
   logic [TO_W-1:0]    to_cnt_q;
   logic [GAP_W-1:0]   gap_cnt_q;

   logic pop;
   logic push;
   logic drop;
   logic to_hit;

   always_comb begin
      pop    = (state_q == StIdle) && (Fifo_Count != '0) && Loop_En;
      // A full FIFO still accepts a byte when the launch frees a slot on the same edge.
      push   = RX_Done_Sig && ((Fifo_Count != CNT_FULL) || pop);
      drop   = RX_Done_Sig && !push;
      to_hit = (state_q == StSend) && !TX_Done_Sig && (to_cnt_q == TO_LAST);
   end

   assign Busy = (state_q != StIdle);

   // Storage carries no reset; only pointers and occupancy define validity.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem[wr_ptr_q] <= RX_Data;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         Fifo_Count <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
         if (push && !pop) begin
            Fifo_Count <= Fifo_Count + CNT_ONE;
         end else if (pop && !push) begin
            Fifo_Count <= Fifo_Count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= StIdle;
         TX_Data      <= 8'h00;
         TX_En_Sig    <= 1'b0;
         to_cnt_q     <= '0;
         gap_cnt_q    <= '0;
         Overflow_Sig <= 1'b0;
         Timeout_Sig  <= 1'b0;
      end else begin
         // Set has priority over clear for both sticky flags.
         Overflow_Sig <= drop | (Overflow_Sig & ~Flag_Clr);
         Timeout_Sig  <= to_hit | (Timeout_Sig & ~Flag_Clr);

         case (state_q)
            StIdle: begin
               if (pop) begin
                  TX_Data   <= mem[rd_ptr_q];
                  TX_En_Sig <= 1'b1;
                  to_cnt_q  <= '0;
                  state_q   <= StSend;
               end
            end
            StSend: begin
               if (TX_Done_Sig) begin
                  TX_En_Sig <= 1'b0;
                  if (GAP_CYCLES == 0) begin
                     state_q <= StIdle;
                  end else begin
                     gap_cnt_q <= GAP_LOAD;
                     state_q   <= StGap;
                  end
               end else if (to_hit) begin
                  // Abandon the byte; the transmitter never answered.
                  TX_En_Sig <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_ONE;
               end
            end
            StGap: begin
               if (gap_cnt_q == '0) begin
                  state_q <= StIdle;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_ONE;
               end
            end
            default: begin
               TX_En_Sig <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_loop_ctrl.sv
module tb_uart_loop_ctrl;

   localparam int unsigned GAP      = 16;
   localparam int unsigned TO_MAIN  = 1000;
   localparam int unsigned TO_SHORT = 50;
   localparam int unsigned DEPTH    = 4;

   logic       CLK = 1'b0;
   logic       RSTn = 1'b0;
   logic [7:0] RX_Data = 8'h00;
   logic       RX_Done_Sig = 1'b0;
   logic       TX_Done_Sig = 1'b0;
   logic       Loop_En = 1'b0;
   logic       Flag_Clr = 1'b0;

   logic [7:0] tx_data, s_tx_data;
   logic       tx_en, s_tx_en;
   logic [2:0] fifo_count, s_fifo_count;
   logic       ovf, s_ovf;
   logic       to_sig, s_to_sig;
   logic       busy, s_busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   uart_loop_ctrl #(.ADDR_W(2), .GAP_CYCLES(GAP), .TO_CYCLES(TO_MAIN)) dut (
      .CLK(CLK), .RSTn(RSTn), .RX_Data(RX_Data), .RX_Done_Sig(RX_Done_Sig),
      .TX_Done_Sig(TX_Done_Sig), .Loop_En(Loop_En), .Flag_Clr(Flag_Clr),
      .TX_Data(tx_data), .TX_En_Sig(tx_en), .Fifo_Count(fifo_count),
      .Overflow_Sig(ovf), .Timeout_Sig(to_sig), .Busy(busy)
   );

   uart_loop_ctrl #(.ADDR_W(2), .GAP_CYCLES(GAP), .TO_CYCLES(TO_SHORT)) dut_to (
      .CLK(CLK), .RSTn(RSTn), .RX_Data(RX_Data), .RX_Done_Sig(RX_Done_Sig),
      .TX_Done_Sig(TX_Done_Sig), .Loop_En(Loop_En), .Flag_Clr(Flag_Clr),
      .TX_Data(s_tx_data), .TX_En_Sig(s_tx_en), .Fifo_Count(s_fifo_count),
      .Overflow_Sig(s_ovf), .Timeout_Sig(s_to_sig), .Busy(s_busy)
   );

   // Reference model of the main instance: a byte queue plus a frame in flight,
   // an age in clocks for that frame and a count of remaining idle-gap clocks.
   logic [7:0] m_q[$];
   bit         m_en = 0;
   logic [7:0] m_data = 8'h00;
   int         m_age = 0;
   int         m_gap = 0;
   bit         m_ovf = 0;
   bit         m_to = 0;
   bit         m_launch, m_acc, m_hit;
   logic [7:0] m_head;

   always @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         m_q.delete();
         m_en = 0; m_data = 8'h00; m_age = 0; m_gap = 0; m_ovf = 0; m_to = 0;
      end else begin
         m_launch = !m_en && (m_gap == 0) && (m_q.size() != 0) && Loop_En;
         m_acc    = RX_Done_Sig && ((m_q.size() < DEPTH) || m_launch);
         m_hit    = 0;
         m_head   = 8'h00;
         if (m_launch) m_head = m_q.pop_front();
         if (m_acc) m_q.push_back(RX_Data);
         if (m_en) begin
            if (TX_Done_Sig) begin
               m_en = 0; m_gap = GAP;
            end else if (m_age + 1 == TO_MAIN) begin
               m_en = 0; m_hit = 1;
            end else begin
               m_age++;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end else if (m_launch) begin
            m_en = 1; m_data = m_head; m_age = 0;
         end
         m_ovf = (RX_Done_Sig && !m_acc) ? 1'b1 : (Flag_Clr ? 1'b0 : m_ovf);
         m_to  = m_hit ? 1'b1 : (Flag_Clr ? 1'b0 : m_to);
      end
   end

   // Every cycle, the main instance must agree with the model.
   always begin
      @(negedge CLK);
      #1;
      n_tests++;
      if (tx_en !== m_en || tx_data !== m_data || fifo_count !== 3'(m_q.size()) ||
          busy !== (m_en || m_gap > 0) || ovf !== m_ovf || to_sig !== m_to) begin
         n_fail++;
         $display("FAIL monitor t=%0t en %b want %b data %h want %h count %0d want %0d busy %b want %b ovf %b want %b to %b want %b",
                  $time, tx_en, m_en, tx_data, m_data, fifo_count, m_q.size(), busy,
                  (m_en || m_gap > 0), ovf, m_ovf, to_sig, m_to);
      end
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic push(input logic [7:0] b);
      RX_Data = b; RX_Done_Sig = 1'b1;
      tick();
      RX_Done_Sig = 1'b0;
   endtask

   task automatic done_pulse();
      TX_Done_Sig = 1'b1;
      tick();
      TX_Done_Sig = 1'b0;
   endtask

   task automatic do_reset();
      RX_Done_Sig = 0; TX_Done_Sig = 0; Flag_Clr = 0; Loop_En = 0;
      RSTn = 1'b0;
      tick(); tick();
      RSTn = 1'b1;
      tick();
   endtask

   task automatic wait_en(output int n);
      n = 0;
      while (!tx_en && n < 300) begin tick(); n++; end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 300) begin tick(); n++; end
   endtask

   task automatic test_reset();
      RSTn = 1'b0;
      tick();
      n_tests++;
      if ({tx_en, busy, ovf, to_sig, fifo_count} !== 7'b0 || tx_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state en/busy/ovf/to/count=%b data=%h want all zero",
                  {tx_en, busy, ovf, to_sig, fifo_count}, tx_data);
      end
      n_tests++;
      if ({s_tx_en, s_busy, s_ovf, s_to_sig, s_fifo_count} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_state_short got %b want 0", {s_tx_en, s_busy, s_ovf, s_to_sig});
      end
      RSTn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [7:0] b = 8'($urandom);
      int n;
      Loop_En = 1'b1;
      push(b);
      n_tests++;
      if (fifo_count !== 3'd1 || tx_en !== 1'b0) begin
         n_fail++;
         $display("FAIL single_queued count=%0d en=%b want 1/0", fifo_count, tx_en);
      end
      tick();
      n_tests++;
      if (tx_en !== 1'b1 || tx_data !== b || fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL single_launch en=%b data=%h count=%0d want 1/%h/0", tx_en, tx_data,
                  fifo_count, b);
      end
      repeat (99) tick();
      n_tests++;
      if (tx_en !== 1'b1) begin
         n_fail++;
         $display("FAIL single_hold en=%b want 1", tx_en);
      end
      done_pulse();
      n_tests++;
      if (tx_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_done en=%b busy=%b want 0/1", tx_en, busy);
      end
      wait_idle(n);
      n_tests++;
      if (n != GAP) begin
         n_fail++;
         $display("FAIL single_gap busy cleared after %0d clocks want %0d", n, GAP);
      end
   endtask

   task automatic test_burst();
      logic [7:0] b[4];
      int peak = 0;
      int n;
      Loop_En = 1'b1;
      foreach (b[i]) b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         push(b[i]);
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
      end
      n_tests++;
      if (peak != 3 || tx_en !== 1'b1 || tx_data !== b[0]) begin
         n_fail++;
         $display("FAIL burst_peak peak=%0d en=%b data=%h want 3/1/%h", peak, tx_en, tx_data, b[0]);
      end
      for (int i = 0; i < 4; i++) begin
         wait_en(n);
         if (i > 0) begin
            n_tests++;
            if (n != GAP + 1) begin
               n_fail++;
               $display("FAIL burst_spacing frame %0d rose %0d clocks after done want %0d",
                        i, n, GAP + 1);
            end
         end
         n_tests++;
         if (tx_data !== b[i]) begin
            n_fail++;
            $display("FAIL burst_order frame %0d data=%h want %h", i, tx_data, b[i]);
         end
         repeat ($urandom_range(2, 30)) tick();
         done_pulse();
      end
      wait_idle(n);
      n_tests++;
      if (busy !== 1'b0 || fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL burst_drain busy=%b count=%0d want 0/0", busy, fifo_count);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b[5];
      int n;
      do_reset();
      foreach (b[i]) b[i] = 8'($urandom);
      for (int i = 0; i < 5; i++) push(b[i]);
      repeat (3) tick();
      n_tests++;
      if (fifo_count !== 3'd4 || ovf !== 1'b1 || tx_en !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_fill count=%0d ovf=%b en=%b want 4/1/0", fifo_count, ovf, tx_en);
      end
      Loop_En = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_en(n);
         n_tests++;
         if (tx_en !== 1'b1 || tx_data !== b[i]) begin
            n_fail++;
            $display("FAIL ovf_order frame %0d en=%b data=%h want 1/%h", i, tx_en, tx_data, b[i]);
         end
         repeat ($urandom_range(1, 10)) tick();
         done_pulse();
      end
      wait_idle(n);
      repeat (5) tick();
      n_tests++;
      if (tx_en !== 1'b0 || fifo_count !== 3'd0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_dropped en=%b count=%0d ovf=%b want 0/0/1", tx_en, fifo_count, ovf);
      end
      Flag_Clr = 1'b1;
      tick();
      Flag_Clr = 1'b0;
      n_tests++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear ovf=%b want 0", ovf);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] b[5];
      int n;
      do_reset();
      foreach (b[i]) b[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) push(b[i]);
      RX_Data = b[4]; RX_Done_Sig = 1'b1; Loop_En = 1'b1;
      tick();
      RX_Done_Sig = 1'b0;
      n_tests++;
      if (fifo_count !== 3'd4 || ovf !== 1'b0 || tx_en !== 1'b1 || tx_data !== b[0]) begin
         n_fail++;
         $display("FAIL full_pop count=%0d ovf=%b en=%b data=%h want 4/0/1/%h", fifo_count, ovf,
                  tx_en, tx_data, b[0]);
      end
      for (int i = 0; i < 5; i++) begin
         wait_en(n);
         n_tests++;
         if (tx_en !== 1'b1 || tx_data !== b[i]) begin
            n_fail++;
            $display("FAIL full_pop_order frame %0d en=%b data=%h want 1/%h", i, tx_en, tx_data, b[i]);
         end
         if (i == 1) Loop_En = 1'b0;
         repeat ($urandom_range(3, 12)) tick();
         done_pulse();
         if (i == 1) begin
            repeat (GAP + 10) tick();
            n_tests++;
            if (tx_en !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd3) begin
               n_fail++;
               $display("FAIL loop_en_hold en=%b busy=%b count=%0d want 0/0/3", tx_en, busy,
                        fifo_count);
            end
            Loop_En = 1'b1;
         end
      end
      wait_idle(n);
      // Clear and set in the same cycle: set must win.
      Loop_En = 1'b0;
      for (int i = 0; i < 4; i++) push(8'($urandom));
      RX_Data = 8'($urandom); RX_Done_Sig = 1'b1; Flag_Clr = 1'b1;
      tick();
      RX_Done_Sig = 1'b0; Flag_Clr = 1'b0;
      n_tests++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL set_wins ovf=%b want 1", ovf);
      end
      Flag_Clr = 1'b1;
      tick();
      Flag_Clr = 1'b0;
      n_tests++;
      if (ovf !== 1'b0 || fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL clr_only ovf=%b count=%0d want 0/4", ovf, fifo_count);
      end
   endtask

   task automatic test_timeout();
      logic [7:0] b0 = 8'($urandom);
      logic [7:0] b1 = 8'($urandom);
      int n = 0;
      do_reset();
      Loop_En = 1'b1;
      push(b0);
      push(b1);
      n_tests++;
      if (s_tx_en !== 1'b1 || s_tx_data !== b0) begin
         n_fail++;
         $display("FAIL to_launch en=%b data=%h want 1/%h", s_tx_en, s_tx_data, b0);
      end
      while (s_tx_en && n < 200) begin tick(); n++; end
      n_tests++;
      if (n != TO_SHORT || s_to_sig !== 1'b1) begin
         n_fail++;
         $display("FAIL to_abort after %0d clocks flag=%b want %0d/1", n, s_to_sig, TO_SHORT);
      end
      tick();
      n_tests++;
      if (s_tx_en !== 1'b1 || s_tx_data !== b1 || s_fifo_count !== 3'd0 || s_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL to_next en=%b data=%h count=%0d want 1/%h/0", s_tx_en, s_tx_data,
                  s_fifo_count, b1);
      end
      Flag_Clr = 1'b1;
      tick();
      Flag_Clr = 1'b0;
      n_tests++;
      if (s_to_sig !== 1'b0 || s_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL to_clear flag=%b ovf=%b want 0/0", s_to_sig, s_ovf);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      Loop_En = 1'b1;
      for (int i = 0; i < 3; i++) push(8'($urandom));
      repeat (3) tick();
      n_tests++;
      if (tx_en !== 1'b1 || fifo_count !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_setup en=%b count=%0d want 1/2", tx_en, fifo_count);
      end
      RSTn = 1'b0;
      #1;
      n_tests++;
      if (tx_en !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset en=%b count=%0d busy=%b want 0/0/0", tx_en, fifo_count, busy);
      end
      tick();
      RSTn = 1'b1;
      repeat (30) tick();
      n_tests++;
      if (tx_en !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_release en=%b count=%0d busy=%b want 0/0/0", tx_en, fifo_count, busy);
      end
   endtask

   task automatic test_random();
      do_reset();
      Loop_En = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         RX_Data     = 8'($urandom);
         RX_Done_Sig = ($urandom_range(0, 5) == 0);
         TX_Done_Sig = tx_en ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 20) == 0);
         Flag_Clr    = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 99) == 0) Loop_En = ~Loop_En;
         tick();
      end
      RX_Done_Sig = 0; TX_Done_Sig = 0; Flag_Clr = 0;
      tick();
   endtask

   initial begin
      tick();
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_full_pop();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_loop_ctrl.md
# uart_loop_ctrl

Loopback sequencer between the UART receiver (`rx_top`) and transmitter (`tx_top`). It buffers each byte received on the `RX_Done_Sig` pulse in a small FIFO. For each byte it drives a `TX_En_Sig` / `TX_Done_Sig` handshake to the transmitter, so back-to-back received bytes are neither lost nor re-sent. It replaces the free-running direct `RX_Data`→`TX_Data` tie in the UART top level and adds overflow and timeout status.

## Interface
Parameters:
- `ADDR_W`, 2: FIFO address width; depth = 2^`ADDR_W` (default 4 entries).
- `GAP_CYCLES`, 16: idle clocks inserted after each `TX_Done_Sig` before the next launch; 0 means no gap.
- `TO_CYCLES`, 1_000_000: maximum clocks in SEND before abort.

Ports:
- `CLK` in 1: system clock.
- `RSTn` in 1: asynchronous reset, active-low.
- `RX_Data` in 8: received byte; valid in the cycle `RX_Done_Sig` is high.
- `RX_Done_Sig` in 1: one-cycle pulse from the receiver.
- `TX_Done_Sig` in 1: one-cycle pulse from the transmitter when the stop bit completes.
- `Loop_En` in 1: 1 = launch frames; 0 = hold queued bytes (the current frame still finishes).
- `Flag_Clr` in 1: clears `Overflow_Sig` and `Timeout_Sig`.
- `TX_Data` out 8: byte presented to the transmitter.
- `TX_En_Sig` out 1: transmit request level.
- `Fifo_Count` out `ADDR_W`+1: current FIFO occupancy.
- `Overflow_Sig` out 1: sticky; a byte was dropped because the FIFO was full.
- `Timeout_Sig` out 1: sticky; a frame was aborted by the timeout.
- `Busy` out 1: high while in SEND or GAP.

## Operation
- FIFO:
  - Circular buffer with `wr_ptr`/`rd_ptr` of `ADDR_W` bits and a separate `Fifo_Count`; pointers wrap modulo depth.
  - Push on `RX_Done_Sig` when `Fifo_Count` < depth, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `Overflow_Sig` is set.
  - Simultaneous push and pop: both are performed and `Fifo_Count` is unchanged.
  - When the FIFO is empty, a push and the IDLE launch do not coincide: the launch sees the updated count one clock later.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if `Fifo_Count` ≠ 0 and `Loop_En`=1, then on this edge load `TX_Data` with the head entry, pop (`rd_ptr`+1, count−1), assert `TX_En_Sig`, clear the timeout counter, and go to SEND.
  - SEND: hold `TX_En_Sig`=1 and `TX_Data` stable; the timeout counter increments each clock.
    - On `TX_Done_Sig`=1: `TX_En_Sig`←0. Go to GAP with gap counter = `GAP_CYCLES`−1, or go to IDLE if `GAP_CYCLES`=0.
    - Otherwise, when the counter reaches `TO_CYCLES`−1: `TX_En_Sig`←0, `Timeout_Sig`←1, go to IDLE. The byte is discarded, not retried.
  - GAP: decrement the gap counter; at 0 go to IDLE. `TX_Done_Sig` is ignored.
- `TX_Done_Sig` seen in IDLE is ignored.
- `Loop_En` is sampled only in IDLE. Deasserting it in SEND or GAP has no effect on the current frame.
- Status flags:
  - If `Flag_Clr` and a set condition occur in the same cycle, the set wins.
  - `Flag_Clr` does not affect the FIFO or the FSM.
- `Busy` is decoded from the state register (high when state ≠ IDLE).

## Timing
- All outputs are registered except `Busy`, which is a decode of a register.
- Reset values (asynchronous, immediate on `RSTn`=0):
  - `TX_Data`=8'h00, `TX_En_Sig`=0, `Fifo_Count`=0, `Overflow_Sig`=0, `Timeout_Sig`=0, `Busy`=0.
  - State=IDLE; pointers and counters at 0.
  - FIFO contents are don't-care.
- Reset in mid-frame drops `TX_En_Sig` at once and empties the FIFO.
- Latency from an empty FIFO:
  - `RX_Done_Sig` high at edge N → `Fifo_Count`=1 after N.
  - `TX_En_Sig`=1 and `TX_Data` valid after edge N+1, with `Fifo_Count` back to 0.
- Next launch: `TX_Done_Sig` high at edge M → `TX_En_Sig`=0 after M → earliest next `TX_En_Sig`=1 after edge M+`GAP_CYCLES`+1.
- Throughput: one frame per transmitter frame time plus `GAP_CYCLES`+1 clocks.

## Test plan
- Single byte: reset, `Loop_En`=1, pulse `RX_Done_Sig` with 8'hA5 → `TX_En_Sig` rises 2 edges later with `TX_Data`=8'hA5. Pulse `TX_Done_Sig` 100 clocks later → `TX_En_Sig` falls next edge and `Busy` clears after 16 GAP clocks.
- Burst and order: push 8'h01..8'h04 on consecutive cycles while `TX_Done_Sig` is held off → `Fifo_Count` peaks at 3 with 8'h01 in flight. Bytes are sent in order 01, 02, 03, 04 with ≥17 clocks between `TX_Done_Sig` and the next rise.
- Overflow: `Loop_En`=0, push 5 bytes → `Fifo_Count`=4 and `Overflow_Sig`=1. Set `Loop_En`=1 → only the first 4 bytes are transmitted. `Flag_Clr` → `Overflow_Sig`=0.
- Full push with simultaneous pop: FIFO full, `Loop_En` rises so IDLE pops in the same cycle as a push → the push is accepted, `Fifo_Count` stays 4, and `Overflow_Sig` stays 0.
- Timeout: `TO_CYCLES`=50, push 8'h3C, never pulse `TX_Done_Sig` → `TX_En_Sig` falls after 50 SEND clocks, `Timeout_Sig`=1, and the next queued byte launches from IDLE.
- Reset mid-operation: assert `RSTn`=0 during SEND with 2 bytes queued → `TX_En_Sig`=0 and `Fifo_Count`=0 immediately. After release, no frame launches without a new `RX_Done_Sig`.
